// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs R/load/store/branch request fields into a
// 32-bit word and tags it with an auto-incrementing byte address.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_class,
  input  logic [2:0]  in_funct3,
  input  logic        in_alt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [12:0] in_imm,
  input  logic        base_load,
  input  logic [31:0] base_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [15:0] count
);

  typedef enum logic [1:0] {
    CLS_R      = 2'b00,
    CLS_LOAD   = 2'b01,
    CLS_STORE  = 2'b10,
    CLS_BRANCH = 2'b11
  } instr_class_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [31:0]  addr_cnt;
  logic [31:0]  enc;
  logic [6:0]   funct7;
  logic         accept;
  logic         reject;
  logic         emit;
  logic         base_take;
  instr_class_e cls;

  assign cls       = instr_class_e'(in_class);
  assign funct7    = in_alt ? 7'b0100000 : 7'b0000000;
  assign base_take = base_load && !out_valid;
  // A base reload steals the cycle so no request can pick up a stale address.
  assign in_ready  = (!out_valid || out_ready) && !base_take;
  assign accept    = in_valid && in_ready;
  assign reject    = accept && (cls == CLS_BRANCH) && in_imm[0];
  assign emit      = out_valid && out_ready;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and a latch can't be inferred.
  always_comb begin
    enc = '0;
    case (cls)
      CLS_R:      enc = {funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      CLS_LOAD:   enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      CLS_STORE:  enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
      CLS_BRANCH: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], OP_BRANCH};
      default:    enc = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      addr_cnt  <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      err <= reject;

      if (accept && !reject) begin
        out_instr <= enc;
        out_addr  <= addr_cnt;
        out_valid <= 1'b1;
        addr_cnt  <= addr_cnt + 32'd4;
      end else if (emit) begin
        out_valid <= 1'b0;
      end

      // base_take implies out_valid=0, so it never coincides with an emit or accept.
      if (base_take) begin
        addr_cnt <= base_addr & 32'hFFFF_FFFC;
        count    <= '0;
      end else if (emit && (count != 16'hFFFF)) begin
        count <= count + 16'd1;
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 in_valid  input  1  request fields valid this cycle.
REQ-004 in_ready  output  1  encoder accepts request this cycle.
REQ-005 in_class  input  2  00 R-type, 01 load, 10 store, 11 branch.
REQ-006 in_funct3  input  3  funct3 field, passed through unchanged.
REQ-007 in_alt  input  1  R-type only: 1 selects funct7=0100000, 0 selects funct7=0000000.
REQ-008 in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-009 in_imm  input  13  two's-complement immediate; load/store use bits [11:0], branch uses [12:0].
REQ-010 base_load  input  1  load base_addr into address counter.
REQ-011 base_addr  input  32  new write address; bits [1:0] forced to 0.
REQ-012 out_valid  output  1  out_instr/out_addr hold an encoded word.
REQ-013 out_ready  input  1  downstream (instruction-memory writer) accepts word.
REQ-014 out_instr  output  32  encoded RV32I instruction.
REQ-015 out_addr  output  32  byte address of out_instr.
REQ-016 err  output  1  one-cycle pulse: request rejected.
REQ-017 count  output  16  words emitted since reset or base_load.

Function
REQ-018 Accept occurs when in_valid && in_ready; emit occurs when out_valid && out_ready.
REQ-019 in_ready = !out_valid || out_ready (single output register, full throughput, combinational ready).
REQ-020 Accepted, valid request: out_instr/out_addr registered next cycle, out_valid=1; latency exactly 1 cycle.
REQ-021 R-type: {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
REQ-022 Load: {imm[11:0], rs1, funct3, rd, 7'b0000011}.
REQ-023 Store: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}.
REQ-024 Branch: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}.
REQ-025 Unused fields per class are ignored and do not affect out_instr.
REQ-026 Branch with in_imm[0]=1 is rejected: consumed (in_ready honoured), err=1 next cycle, no word emitted, address/count unchanged.
REQ-027 out_addr = address counter at accept; counter += 4 per accepted non-rejected request, wrapping 0xFFFFFFFC -> 0x00000000.
REQ-028 count += 1 per emit; saturates at 0xFFFF.
REQ-029 While out_valid && !out_ready: out_instr, out_addr held stable; no new accept.
REQ-030 Simultaneous emit and accept in same cycle: new word replaces old, out_valid stays 1, no bubble.
REQ-031 base_load while out_valid=0: counter=base_addr&~3, count=0, in_ready=0 that cycle.
REQ-032 base_load while out_valid=1: ignored; caller must drain first.

Reset
REQ-033 reset: out_valid=0, out_instr=0, out_addr=0, address counter=0, count=0, err=0; takes effect on the edge even mid-transfer, pending word discarded.
REQ-034 in_ready=1 in the first cycle after reset deasserts.

Verification
REQ-035 add x3,x1,x2 (class 00, f3 0, alt 0), out_ready=1 -> out_instr=0x002081B3, out_addr=0, next cycle out_valid=1; alt=1 -> 0x402081B3 at out_addr=4.
REQ-036 lw x5,8(x2) then sw x5,12(x2) back-to-back -> 0x00812283 at addr 0, then 0x00512623 at addr 4, no bubble, count=2.
REQ-037 beq x1,x2,-8 (imm 0x1FF8) -> 0x FE208CE3; imm 0x0003 -> err pulse, no out_valid, next word still at following address.
REQ-038 out_ready=0 for 5 cycles with word pending -> in_ready=0, outputs stable; release -> word emitted once, next request accepted same cycle.
REQ-039 base_load 0xFFFFFFFE, then 2 requests -> out_addr 0xFFFFFFFC then 0x00000000, count=2.
REQ-040 reset asserted with out_valid=1, out_ready=0 -> next cycle out_valid=0, count=0, out_addr=0; first later request emitted at addr 0.
